// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU engine owning the HI/LO pair, with MFHI/MFLO read port.
// Optional MTHI/MTLO write ports are enabled by defining HILO_MTHILO_EN.
module hilo_muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        lh_sel,
`ifdef HILO_MTHILO_EN
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] mt_data,
`endif
  output logic [DATA_W-1:0] lh_out,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W:0]       rem_q, rem_d;
  logic [DATA_W-1:0]     quo_q, quo_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  done_q, done_d;

  logic [DATA_W:0]       mul_sum;
  logic [2*DATA_W-1:0]   mul_step;
  logic [DATA_W:0]       div_shift;
  logic [DATA_W+1:0]     div_diff;
  logic                  div_ge;
  logic [DATA_W:0]       div_rem;
  logic [DATA_W-1:0]     div_quo;
  logic                  mt_req;

  // Shift-add step: add multiplicand into upper half when multiplier LSB is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step = {mul_sum, acc_q[DATA_W-1:1]};
  end

  // Restoring step: the extra MSB of the difference is the borrow, so ge means non-negative.
  always_comb begin
    div_shift = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    div_ge    = ~div_diff[DATA_W+1];
    div_rem   = div_ge ? div_diff[DATA_W:0] : div_shift;
    div_quo   = {quo_q[DATA_W-2:0], div_ge};
  end

`ifdef HILO_MTHILO_EN
  assign mt_req = mthi | mtlo;
`else
  assign mt_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef HILO_MTHILO_EN
        if (mthi) hi_d = mt_data;
        if (mtlo) lo_d = mt_data;
`endif
        if (start) begin
          cnt_d   = '0;
          opnd_d  = op ? b : a;
          acc_d   = {{DATA_W{1'b0}}, b};
          rem_d   = '0;
          quo_d   = a;
          state_d = op ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          {hi_d, lo_d} = mul_step;
          done_d       = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_DIV: begin
        rem_d = div_rem;
        quo_d = div_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          hi_d    = div_rem[DATA_W-1:0];
          lo_d    = div_quo;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Any HI/LO access or new request while busy must hold the pipeline until the result lands.
  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | (lh_sel != 2'b00) | mt_req);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  always_comb begin
    case (lh_sel)
      2'b01:   lh_out = lo_q;
      2'b10:   lh_out = hi_q;
      default: lh_out = '0;
    endcase
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit; MTHI/MTLO steps run when HILO_MTHILO_EN is defined.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  lh_sel;
  logic [31:0] lh_out;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
`ifdef HILO_MTHILO_EN
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;

  always #5 clk = ~clk;

  hilo_muldiv_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .lh_sel (lh_sel),
`ifdef HILO_MTHILO_EN
    .mthi   (mthi),
    .mtlo   (mtlo),
    .mt_data(mt_data),
`endif
    .lh_out (lh_out),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion, checking latency, hold and result.
  task automatic run_op(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                        input logic o, input logic [31:0] eh, input logic [31:0] el);
    int n;
    a = aa; b = bb; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 31) begin
        check({tag, "_hi_held"}, hi, model_hi);
        check({tag, "_lo_held"}, lo, model_lo);
      end
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd32);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    model_hi = eh;
    model_lo = el;
    tick();
    check({tag, "_done_clear"}, {31'b0, done}, 32'd0);
    $display("txn %s a=%h b=%h op=%0d hi=%h lo=%h cycles=%0d", tag, aa, bb, o, hi, lo, n);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; lh_sel = 2'b00;
`ifdef HILO_MTHILO_EN
    mthi = 1'b0; mtlo = 1'b0; mt_data = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    $display("txn reset hi=%h lo=%h busy=%0d", hi, lo, busy);

    run_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_100_7", 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);

    lh_sel = 2'b10; #1;
    check("mfhi", lh_out, 32'd2);
    check("idle_read_stall", {31'b0, stall}, 32'd0);
    lh_sel = 2'b01; #1;
    check("mflo", lh_out, 32'd14);
    lh_sel = 2'b11; #1;
    check("no_read", lh_out, 32'd0);
    lh_sel = 2'b00;
    $display("txn reads hi=2 lo=14 sel11=%h", lh_out);

    run_op("divu_by_zero", 32'h1234_5678, 32'h0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("multu_small", 32'd123456, 32'd789, 1'b0, 32'h0, 32'd97406784);

    // Hazard: MFLO issued while a divide runs, plus a stray start that must be ignored.
    a = 32'd1000; b = 32'd3; op = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    lh_sel = 2'b01; #1;
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      if (n == 5) begin
        start = 1'b1; a = 32'd7; b = 32'd7; op = 1'b0;
      end
      if (n == 6) start = 1'b0;
      n++;
      tick();
    end
    check("hazard_stall_cycles", 32'(n), 32'd31);
    check("hazard_lh_out", lh_out, 32'd333);
    check("hazard_hi", hi, 32'd1);
    check("hazard_done", {31'b0, done}, 32'd1);
    lh_sel = 2'b00;
    tick();
    check("hazard_idle", {31'b0, busy}, 32'd0);
    check("hazard_lo_kept", lo, 32'd333);
    model_hi = 32'd1; model_lo = 32'd333;
    $display("txn hazard stall_cycles=%0d lh_out=%h hi=%h", n, lh_out, hi);

`ifdef HILO_MTHILO_EN
    mtlo = 1'b1; mt_data = 32'hA5A5_A5A5;
    tick();
    mtlo = 1'b0;
    check("mtlo_lo", lo, 32'hA5A5_A5A5);
    check("mtlo_hi_kept", hi, 32'd1);
    model_lo = 32'hA5A5_A5A5;
    $display("txn mtlo lo=%h", lo);

    a = 32'd3; b = 32'd5; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; mthi = 1'b1; mt_data = 32'hDEAD_BEEF; #1;
    check("mthi_stall", {31'b0, stall}, 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("mthi_mul_hi", hi, 32'd0);
    check("mthi_mul_lo", lo, 32'd15);
    tick();
    mthi = 1'b0;
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", lo, 32'd15);
    model_hi = 32'hDEAD_BEEF; model_lo = 32'd15;
    $display("txn mthi_during_mul hi=%h lo=%h", hi, lo);
`endif

    // Reset mid-divide: partial work discarded, no completion pulse afterwards.
    a = 32'd100; b = 32'd7; op = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    $display("txn midrst hi=%h lo=%h busy=%0d done_pulses=%0d", hi, lo, busy, pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide engine that owns the HI/LO register pair.
- Executes the MULTU/DIVU requests flagged by the instruction decoder through ToLH, and answers MFHI/MFLO reads selected by LHToReg.
- Sits beside the ALU in EX and raises a stall to the pipeline while an operation is in flight.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request: decoder ToLH qualified by a valid instruction
- op  in  1  0 = MULTU, 1 = DIVU
- a  in  DATA_W  rs operand (multiplicand / dividend)
- b  in  DATA_W  rt operand (multiplier / divisor)
- lh_sel  in  2  decoder LHToReg: 01 = read LO, 10 = read HI, 00/11 = no read
- lh_out  out  DATA_W  read data into the register-file Din mux
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register
- busy  out  1  operation in flight
- stall  out  1  pipeline hold request
- done  out  1  one-cycle pulse when HI/LO update

Behaviour:
- Reset: in the cycle after rst is sampled high, state = IDLE and hi = lo = 0; busy, stall and done are 0. rst aborts any in-flight operation and discards the partial result.
- States: IDLE, MUL, DIV.
- IDLE, start = 1 at edge E0: latch a and b, clear the iteration counter, and go to MUL (op = 0) or DIV (op = 1). busy = 1 from E0 onward.
- MUL: radix-2 shift-add, one multiplier bit per cycle, with a 2*DATA_W accumulator. Product is exact with no overflow.
- DIV: restoring division, one quotient bit per cycle. Partial remainder is DATA_W+1 bits wide. Quotient bit = 1 when the trial subtraction is non-negative.
- Iteration edges are E1..E32. At E32: {hi, lo} = product, or hi = remainder and lo = quotient. At the same edge busy → 0, state → IDLE, and done = 1 for the following cycle only.
- Latency: the result is visible on hi/lo exactly DATA_W cycles after the start edge.
- Divide by zero needs no special logic and the result is defined: lo = all ones (0xFFFFFFFF), hi = a.
- start while busy is ignored. The pipeline is held by stall, so it is never lost.
- start in the same cycle that busy falls: busy is still 1 in that cycle, so the request is held by stall and accepted on the next edge.
- hi/lo change only at completion, reset, or the optional writes.
- lh_out is combinational: lh_sel = 01 → lo; 10 → hi; else 0.
- stall = busy & (start | lh_sel != 00).
  - MFHI/MFLO never return a stale value.
  - Independent instructions continue while busy.
- No back-to-back acceptance: a new start is accepted in IDLE only.

Optional Feature:
- Macro HILO_MTHILO_EN. When defined, add ports:
  - mthi  in  1
  - mtlo  in  1
  - mt_data  in  DATA_W
- In IDLE, mthi/mtlo write mt_data into hi/lo at the next edge. mthi and mtlo together write both registers.
- mthi/mtlo while busy: stall is also asserted; the write is held and applied once IDLE.
- If start and mt* are asserted in the same IDLE cycle, mt* takes effect first and start is accepted at the same edge. The later result overwrites.
- When the macro is not defined, none of these ports exist and hi/lo are written only by completion and reset.

Test Plan:
- Reset: hold rst for 2 cycles mid-DIV → hi = lo = 0, busy = 0 the cycle after; no done pulse.
- MULTU: a = 0xFFFFFFFF, b = 0xFFFFFFFF, start → busy for 32 cycles; then hi = 0xFFFFFFFE, lo = 0x00000001, done high 1 cycle.
- DIVU: a = 100, b = 7 → after 32 cycles lo = 14, hi = 2; then lh_sel = 10 gives lh_out = 2.
- Divide by zero: a = 0x12345678, b = 0 → lo = 0xFFFFFFFF, hi = 0x12345678.
- Hazard: lh_sel = 01 asserted 1 cycle after start → stall = 1 for 31 cycles. lh_out = new lo when stall falls. A start issued while busy is ignored with no hi/lo corruption.
- HILO_MTHILO_EN: mtlo with mt_data = 0xA5A5A5A5 in IDLE → lo = 0xA5A5A5A5 next cycle. mthi during MULTU 3×5 → stall = 1, hi = 0 from the product, then hi = mt_data one cycle after IDLE.
